// File: rtl/fsk_pkg.sv
// rtl/fsk_pkg.sv - shared states, defaults and preamble constant for the FSK frame scheduler
package fsk_pkg;

    localparam int DEF_FRAME_W      = 16;
    localparam int DEF_BIT_CYCLES   = 16;
    localparam int DEF_GUARD_CYCLES = 4;

    localparam logic [15:0] PREAMBLE = 16'hAAAA;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        PRE,
        SEND
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, pointer flips away from each granted requester
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // ptr = 0 favours requester 0 when both request
    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !ptr)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/fsk_tx_sched.sv
// rtl/fsk_tx_sched.sv - frame scheduler sharing one 2-FSK modulator between two requesters
// Optional preamble frame before each data frame is enabled by defining FSK_PREAMBLE_EN.
module fsk_tx_sched
    import fsk_pkg::*;
#(
    parameter int FRAME_W      = DEF_FRAME_W,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         req_valid,
    input  logic [FRAME_W-1:0] req_data0,
    input  logic [FRAME_W-1:0] req_data1,
    output logic [1:0]         req_ready,
    output logic [FRAME_W-1:0] mod_data,
    output logic               mod_rst,
    output logic               busy,
    output logic               grant_id,
    output logic               frame_done
);

    localparam int FRAME_CYCLES = FRAME_W * BIT_CYCLES;
    localparam int CNT_W        = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'((GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1);
`ifdef FSK_PREAMBLE_EN
    localparam state_t AFTER_GUARD = PRE;
`else
    localparam state_t AFTER_GUARD = SEND;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               grant_q, grant_d;
    logic               done_q, done_d;
    logic [1:0]         arb_gnt;
    logic               handshake;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (handshake),
        .gnt     (arb_gnt)
    );

    assign req_ready  = (state_q == IDLE && enable) ? arb_gnt : 2'b00;
    assign handshake  = |(req_ready & req_valid);
    assign busy       = (state_q != IDLE);
    assign grant_id   = grant_q;
    assign frame_done = done_q;

`ifdef FSK_PREAMBLE_EN
    // Last preamble cycle pulls the modulator back into reset so the frame starts at MSB
    logic realign_q, realign_d;
    assign mod_rst  = (state_q == SEND) || (state_q == PRE && !realign_q);
    assign mod_data = (state_q == PRE) ? FRAME_W'(PREAMBLE) : frame_q;
`else
    assign mod_rst  = (state_q == SEND);
    assign mod_data = frame_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        grant_d = grant_q;
        done_d  = 1'b0;
`ifdef FSK_PREAMBLE_EN
        realign_d = realign_q;
`endif
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    frame_d = req_ready[1] ? req_data1 : req_data0;
                    grant_d = req_ready[1];
                    cnt_d   = '0;
                    state_d = (GUARD_CYCLES == 0) ? AFTER_GUARD : GUARD;
                end
            end
            GUARD: begin
                if (cnt_q == GUARD_END) begin
                    cnt_d   = '0;
                    state_d = AFTER_GUARD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRE: begin
`ifdef FSK_PREAMBLE_EN
                if (realign_q) begin
                    realign_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = SEND;
                end else if (cnt_q == LAST_CNT) begin
                    realign_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            SEND: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            frame_q <= '0;
            grant_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef FSK_PREAMBLE_EN
            realign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            grant_q <= grant_d;
            done_q  <= done_d;
`ifdef FSK_PREAMBLE_EN
            realign_q <= realign_d;
`endif
        end
    end

endmodule

// File: tb/tb_fsk_tx_sched.sv
// tb/tb_fsk_tx_sched.sv - directed self-checking bench for fsk_tx_sched
module tb_fsk_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  req_valid;
    logic [15:0] req_data0;
    logic [15:0] req_data1;
    logic [1:0]  req_ready;
    logic [15:0] mod_data;
    logic        mod_rst;
    logic        busy;
    logic        grant_id;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          off;
        logic        exp_mod_rst;
        logic        exp_busy;
        logic        exp_done;
        logic [15:0] exp_data;
    } vec_t;

    fsk_tx_sched dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_ready  (req_ready),
        .mod_data   (mod_data),
        .mod_rst    (mod_rst),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        enable    = 1'b1;
        req_valid = 2'b00;
        req_data0 = '0;
        req_data1 = '0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!frame_done && n < 700) begin
            step();
            n++;
        end
        check(name, frame_done, 1'b1);
    endtask

    vec_t tbl[$];
    int   cur;

    initial begin
`ifdef FSK_PREAMBLE_EN
        tbl.push_back('{1,   1'b0, 1'b1, 1'b0, 16'hA5C3});
        tbl.push_back('{4,   1'b0, 1'b1, 1'b0, 16'hA5C3});
        tbl.push_back('{5,   1'b1, 1'b1, 1'b0, 16'hAAAA});
        tbl.push_back('{260, 1'b1, 1'b1, 1'b0, 16'hAAAA});
        tbl.push_back('{261, 1'b0, 1'b1, 1'b0, 16'hAAAA});
        tbl.push_back('{262, 1'b1, 1'b1, 1'b0, 16'hA5C3});
        tbl.push_back('{517, 1'b1, 1'b1, 1'b0, 16'hA5C3});
        tbl.push_back('{518, 1'b0, 1'b0, 1'b1, 16'hA5C3});
        tbl.push_back('{519, 1'b0, 1'b0, 1'b0, 16'hA5C3});
`else
        tbl.push_back('{1,   1'b0, 1'b1, 1'b0, 16'hA5C3});
        tbl.push_back('{4,   1'b0, 1'b1, 1'b0, 16'hA5C3});
        tbl.push_back('{5,   1'b1, 1'b1, 1'b0, 16'hA5C3});
        tbl.push_back('{100, 1'b1, 1'b1, 1'b0, 16'hA5C3});
        tbl.push_back('{260, 1'b1, 1'b1, 1'b0, 16'hA5C3});
        tbl.push_back('{261, 1'b0, 1'b0, 1'b1, 16'hA5C3});
        tbl.push_back('{262, 1'b0, 1'b0, 1'b0, 16'hA5C3});
`endif

        // Reset state
        rst       = 1'b0;
        enable    = 1'b1;
        req_valid = 2'b00;
        req_data0 = '0;
        req_data1 = '0;
        #3;
        check("rst_mod_rst", mod_rst, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mod_data", mod_data, 16'h0000);
        check("rst_done", frame_done, 1'b0);
        check("rst_grant", grant_id, 1'b0);
        step();
        rst = 1'b1;
        step();

        // Single frame from requester 0, timing walked through the table
        req_valid = 2'b01;
        req_data0 = 16'hA5C3;
        #1;
        check("s1_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        cur = 1;
        check("s1_grant", grant_id, 1'b0);
        foreach (tbl[i]) begin
            while (cur < tbl[i].off) begin
                step();
                cur++;
            end
            check($sformatf("t%0d_mod_rst", tbl[i].off), mod_rst, tbl[i].exp_mod_rst);
            check($sformatf("t%0d_busy", tbl[i].off), busy, tbl[i].exp_busy);
            check($sformatf("t%0d_done", tbl[i].off), frame_done, tbl[i].exp_done);
            check($sformatf("t%0d_data", tbl[i].off), mod_data, tbl[i].exp_data);
            check($sformatf("t%0d_ready", tbl[i].off), req_ready, 2'b00);
        end

        // Both valid from reset: req0 first, req1 granted in req0's done cycle
        do_reset();
        req_valid = 2'b11;
        req_data0 = 16'h1111;
        req_data1 = 16'h2222;
        #1;
        check("s2_ready0", req_ready, 2'b01);
        step();
        req_valid = 2'b10;
        check("s2_grant0", grant_id, 1'b0);
        wait_done("s2_done0");
        check("s2_ready1", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        check("s2_grant1", grant_id, 1'b1);
        check("s2_busy1", busy, 1'b1);
        check("s2_data1", mod_data, 16'h2222);
        wait_done("s2_done1");

        // req1 held continuously, req0 arrives later: grants 1,0,1
        do_reset();
        req_valid = 2'b10;
        req_data1 = 16'h3333;
        #1;
        check("s3_ready_a", req_ready, 2'b10);
        step();
        check("s3_grant_a", grant_id, 1'b1);
        repeat (10) step();
        req_valid = 2'b11;
        req_data0 = 16'h4444;
        wait_done("s3_done_a");
        check("s3_ready_b", req_ready, 2'b01);
        step();
        req_valid = 2'b10;
        check("s3_grant_b", grant_id, 1'b0);
        check("s3_data_b", mod_data, 16'h4444);
        wait_done("s3_done_b");
        check("s3_ready_c", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        check("s3_grant_c", grant_id, 1'b1);
        wait_done("s3_done_c");

        // enable dropped mid-frame: frame completes, no grants until enable returns
        do_reset();
        req_valid = 2'b01;
        req_data0 = 16'h5A5A;
        step();
        req_valid = 2'b00;
        repeat (20) step();
        enable    = 1'b0;
        req_valid = 2'b10;
        wait_done("s4_done");
        check("s4_ready_done", req_ready, 2'b00);
        repeat (3) step();
        check("s4_idle_busy", busy, 1'b0);
        check("s4_idle_ready", req_ready, 2'b00);
        req_valid = 2'b00;
        step();
        enable = 1'b1;
        #1;
        check("s4_dropped_valid", req_ready, 2'b00);
        step();
        check("s4_no_grant_busy", busy, 1'b0);
        req_valid = 2'b10;
        #1;
        check("s4_reenable_ready", req_ready, 2'b10);

        // Reset in the middle of a frame, then a fresh request
        do_reset();
        req_valid = 2'b01;
        req_data0 = 16'h0F0F;
        step();
        req_valid = 2'b00;
        repeat (99) step();
        check("s5_pre_mod_rst", mod_rst, 1'b1);
        rst = 1'b0;
        #1;
        check("s5_mod_rst", mod_rst, 1'b0);
        check("s5_busy", busy, 1'b0);
        check("s5_mod_data", mod_data, 16'h0000);
        step();
        rst = 1'b1;
        step();
        req_valid = 2'b10;
        req_data1 = 16'hBEEF;
        #1;
        check("s5_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        check("s5_busy_after", busy, 1'b1);
        check("s5_grant_after", grant_id, 1'b1);
        wait_done("s5_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
